// File: rtl/pcie_dll_tx_replay_buffer.sv
// -----------------------------------------------------------------------------
// pcie_dll_tx_replay_buffer
//
// Data link layer TX replay buffer for PCIe. Each single-beat TLP accepted from
// the transaction layer gets a 12-bit sequence number. The buffer forwards the
// TLP to the link side and keeps a copy until an ACK covers it. A NAK rewinds
// the send pointer to the oldest unacknowledged entry and replays in order.
//
// Optional build feature (macro PCIE_REPLAY_TIMER_EN): a replay timer that
// triggers a rewind on its own after REPLAY_TIMEOUT cycles without ACK progress.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              TLP handshake from the transaction layer
//   in_header/in_data/in_sop/in_eop TLP contents (stored and forwarded)
//   out_valid/out_ready            TLP handshake towards the link side
//   out_header/out_data/out_sop/out_eop/out_seq  presented TLP and its number
//   ack_valid/ack_nak/ack_seq      received ACK/NAK DLLP
//   replay_active                  replay in progress
//   occupancy                      entries held (unsent + unacknowledged)
//   err_bad_ack                    one-cycle pulse: ACK/NAK outside the window
// -----------------------------------------------------------------------------
module pcie_dll_tx_replay_buffer #(
    parameter int DEPTH          = 8,
    parameter int HDR_W          = 128,
    parameter int DATA_W         = 256,
    parameter int SEQ_W          = 12,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [HDR_W-1:0]         in_header,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [HDR_W-1:0]         out_header,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [SEQ_W-1:0]         out_seq,
    input  logic                     out_ready,
    input  logic                     ack_valid,
    input  logic                     ack_nak,
    input  logic [SEQ_W-1:0]         ack_seq,
    output logic                     replay_active,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_bad_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = HDR_W + DATA_W + 2 + SEQ_W;

    logic [EW-1:0]    mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r, send_ptr_r, ack_ptr_r, replay_end_r, occupancy_r;
    logic [SEQ_W-1:0] next_seq_r, acked_seq_r;
    logic             replay_active_r, err_bad_ack_r, in_ready_r;

    logic [PW-1:0]    wr_ptr_nxt, send_ptr_nxt, ack_ptr_nxt, replay_end_nxt, occupancy_nxt;
    logic [SEQ_W-1:0] next_seq_nxt, acked_seq_nxt, d_s;
    logic [PW-1:0]    sent_unacked_s;
    logic             replay_active_nxt, err_bad_ack_nxt, in_ready_nxt;
    logic             wr_fire_s, send_fire_s, in_window_s, ack_ok_s, ack_progress_s, nak_s;
    logic             timer_fire_s;
    logic             out_valid_s;

    assign out_valid_s   = (send_ptr_r != wr_ptr_r);
    assign out_valid     = out_valid_s;
    assign {out_header, out_data, out_sop, out_eop, out_seq} = mem_r[send_ptr_r[AW-1:0]];
    assign in_ready      = in_ready_r;
    assign occupancy     = occupancy_r;
    assign replay_active = replay_active_r;
    assign err_bad_ack   = err_bad_ack_r;

    // Next-state computation: ACK/NAK window, rewind, send and write pointers.
    always_comb begin
        wr_fire_s      = in_valid && in_ready_r;
        send_fire_s    = out_valid_s && out_ready;
        sent_unacked_s = send_ptr_r - ack_ptr_r;
        // Distance from the last acknowledged number, modulo the sequence space.
        d_s            = ack_seq - acked_seq_r;
        in_window_s    = (d_s != {SEQ_W{1'b0}}) && (d_s <= SEQ_W'(sent_unacked_s));
        ack_ok_s       = ack_valid && ((d_s == {SEQ_W{1'b0}}) || in_window_s);
        ack_progress_s = ack_valid && in_window_s;
        nak_s          = ack_ok_s && ack_nak;
        err_bad_ack_nxt = ack_valid && !ack_ok_s;

        if (ack_progress_s) begin
            // d never exceeds DEPTH here, so its low PW bits are the release count.
            ack_ptr_nxt   = ack_ptr_r + d_s[PW-1:0];
            acked_seq_nxt = ack_seq;
        end else begin
            ack_ptr_nxt   = ack_ptr_r;
            acked_seq_nxt = acked_seq_r;
        end

        if (wr_fire_s) begin
            wr_ptr_nxt   = wr_ptr_r + PW'(1);
            next_seq_nxt = next_seq_r + SEQ_W'(1);
        end else begin
            wr_ptr_nxt   = wr_ptr_r;
            next_seq_nxt = next_seq_r;
        end

        replay_end_nxt    = replay_end_r;
        replay_active_nxt = replay_active_r;
        if (nak_s || timer_fire_s) begin
            // Rewind beats any same-cycle send handshake.
            send_ptr_nxt      = ack_ptr_nxt;
            replay_end_nxt    = send_ptr_r;
            replay_active_nxt = (ack_ptr_nxt != send_ptr_r);
        end else if (send_fire_s) begin
            send_ptr_nxt = send_ptr_r + PW'(1);
            if (replay_active_r && (send_ptr_nxt == replay_end_r)) begin
                replay_active_nxt = 1'b0;
            end else begin
                replay_active_nxt = replay_active_r;
            end
        end else begin
            send_ptr_nxt = send_ptr_r;
        end

        occupancy_nxt = wr_ptr_nxt - ack_ptr_nxt;
        in_ready_nxt  = (occupancy_nxt != PW'(DEPTH));
    end

`ifdef PCIE_REPLAY_TIMER_EN
    localparam int TW = $clog2(REPLAY_TIMEOUT) + 1;
    logic [TW-1:0] timer_r;

    assign timer_fire_s = (sent_unacked_s != {PW{1'b0}}) && !ack_progress_s && !nak_s &&
                          (timer_r == TW'(REPLAY_TIMEOUT - 1));

    // Replay timer: counts while TLPs are outstanding, restarts on ACK progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TW{1'b0}};
        end else if (ack_progress_s || nak_s || timer_fire_s ||
                     (sent_unacked_s == {PW{1'b0}})) begin
            timer_r <= {TW{1'b0}};
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end
`else
    assign timer_fire_s = 1'b0;
`endif

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r        <= {PW{1'b0}};
            send_ptr_r      <= {PW{1'b0}};
            ack_ptr_r       <= {PW{1'b0}};
            replay_end_r    <= {PW{1'b0}};
            occupancy_r     <= {PW{1'b0}};
            next_seq_r      <= {SEQ_W{1'b0}};
            acked_seq_r     <= {SEQ_W{1'b1}};
            replay_active_r <= 1'b0;
            err_bad_ack_r   <= 1'b0;
            in_ready_r      <= 1'b1;
        end else begin
            wr_ptr_r        <= wr_ptr_nxt;
            send_ptr_r      <= send_ptr_nxt;
            ack_ptr_r       <= ack_ptr_nxt;
            replay_end_r    <= replay_end_nxt;
            occupancy_r     <= occupancy_nxt;
            next_seq_r      <= next_seq_nxt;
            acked_seq_r     <= acked_seq_nxt;
            replay_active_r <= replay_active_nxt;
            err_bad_ack_r   <= err_bad_ack_nxt;
            in_ready_r      <= in_ready_nxt;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_header, in_data, in_sop, in_eop, next_seq_r};
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: doc/pcie_dll_tx_replay_buffer.md
Name: pcie_dll_tx_replay_buffer

Overview:
- Downstream neighbour of the PCIe Gen5 transaction layer (TL) TX port.
- Accepts single-beat TLPs (header + data) from the TL and assigns each a 12-bit sequence number.
- Forwards TLPs to the link/PHY side over a valid/ready handshake and keeps a copy until it is ACKed.
- A NAK rewinds transmission and replays every unacknowledged TLP in order.

Parameters:
DEPTH, 8, number of TLP entries held (power of 2, 2..64)
HDR_W, 128, TLP header width
DATA_W, 256, TLP payload width
SEQ_W, 12, sequence number width (fixed by PCIe; modulo 4096)
REPLAY_TIMEOUT, 1024, cycles without ACK progress before self-triggered replay (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  TLP offered by TL
in_header  in  HDR_W  TLP header
in_data  in  DATA_W  TLP payload
in_sop  in  1  start of packet (stored and forwarded)
in_eop  in  1  end of packet (stored and forwarded)
in_ready  out  1  buffer can accept; wired to the TL's tx_ready
out_valid  out  1  TLP presented to link side
out_header  out  HDR_W  header of presented TLP
out_data  out  DATA_W  payload of presented TLP
out_sop  out  1  stored sop
out_eop  out  1  stored eop
out_seq  out  SEQ_W  sequence number of presented TLP
out_ready  in  1  link side accepts
ack_valid  in  1  ACK/NAK DLLP received
ack_nak  in  1  0 = ACK, 1 = NAK
ack_seq  in  SEQ_W  AckNak_Seq_Num
replay_active  out  1  replay in progress
occupancy  out  $clog2(DEPTH)+1  entries held (unsent + unacked)
err_bad_ack  out  1  one-cycle pulse: ACK/NAK outside window

Behaviour:
- Reset: clk, rst_n asynchronous active-low. All pointers 0, next_seq = 0, acked_seq = 4095, out_valid = 0, replay_active = 0, occupancy = 0, err_bad_ack = 0, in_ready = 1. Memory contents are don't-care.
- Pointers: wr_ptr, send_ptr and ack_ptr are each $clog2(DEPTH)+1 bits wide.
  - occupancy = wr_ptr - ack_ptr.
  - full = (occupancy == DEPTH).
  - in_ready = !full, driven from registers.
- Write: on in_valid && in_ready, store {header, data, sop, eop, next_seq} at wr_ptr. wr_ptr++. next_seq = next_seq + 1 mod 4096.
- Send: out_valid = (send_ptr != wr_ptr). out_* come from entry[send_ptr].
  - An entry written in cycle N is presentable in cycle N+1.
  - On out_valid && out_ready, send_ptr++.
  - out_* are held stable while out_valid && !out_ready. The only exceptions are a NAK/timer rewind or reset, which withdraw the current beat.
- ACK/NAK window: sent_unacked = send_ptr - ack_ptr. d = (ack_seq - acked_seq) mod 4096.
  - d in 1..sent_unacked: release d entries. ack_ptr += d; acked_seq = ack_seq.
  - d == 0: duplicate; no release, no error.
  - Otherwise: ignore the ACK/NAK and pulse err_bad_ack the next cycle.
- NAK: perform the release above (including d == 0), then in the same update set send_ptr = new ack_ptr.
  - Capture replay_end = send_ptr as it stood before the NAK.
  - Set replay_active = 1. It clears in the cycle send_ptr reaches replay_end.
  - A NAK with nothing left to replay leaves replay_active = 0.
- Simultaneous events:
  - A write and an ACK/NAK in the same cycle are both applied.
  - Space freed by an ACK raises in_ready the following cycle.
  - A send handshake in the same cycle as a NAK is discarded; the rewind wins.
  - A NAK during replay re-captures replay_end and rewinds again.
- Wrap-around: pointers wrap naturally. Sequence arithmetic is always mod 4096. DEPTH ≤ 64 keeps the window well below 2048.
- Reset mid-operation: all held TLPs are discarded; numbering restarts at 0.

Optional Feature:
- Macro: PCIE_REPLAY_TIMER_EN.
- Defined:
  - A counter runs while sent_unacked > 0. It resets to 0 on any valid ACK/NAK with d ≥ 1, and holds at 0 when sent_unacked == 0.
  - On reaching REPLAY_TIMEOUT-1, perform a NAK-style rewind without release (send_ptr = ack_ptr, replay_active = 1) and reset the counter.
- Undefined: no counter; replay occurs only on NAK.

Test Plan:
- Reset, then 3 TLPs with out_ready = 1 → out_seq 0, 1, 2 in order, with header/data matching; occupancy = 3.
- Fill 8 TLPs with out_ready = 0 → in_ready = 0 after the 8th; a 9th offer is not accepted.
- Send 8, then ACK seq 3 → occupancy 4 and in_ready = 1 next cycle. Then ACK seq 7 → occupancy 0.
- Send seq 0..5, then NAK seq 2 → ack_ptr advances by 3; seq 3, 4, 5 are re-sent with identical contents. replay_active is 1 until seq 5 is accepted, then new TLPs carry seq 6.
- ACK seq 9 while only seq 0..4 are sent → err_bad_ack pulse; occupancy unchanged.
- Force next_seq to wrap: send 4094..4095, 0, 1, then ACK seq 0 → 3 entries released. With PCIE_REPLAY_TIMER_EN and no ACK for 1024 cycles → replay starts from the oldest unacked TLP.
